// File: rtl/idct_pkg.sv
// ---------------------------------------------------------------------------
// idct_pkg
//   Shared constants, FSM state type and constant helper functions for the
//   sequential 8-point row IDCT (idct_row_mac).
//
//   Contents:
//     N_PT, COEF_W, PIX_W, W_W : point count and field widths
//     state_t                  : IDLE / ACC / OUT
//     gen_w_table(frac)        : packed 8x8 table of signed 13-bit weights
//                                W[k][n] = round(2^frac * 2*C(k)*cos((2n+1)k*pi/16))
//     lowest_set(mask)         : index of the lowest set bit of an 8-bit mask
//
//   No configuration macros are used in this file.
// ---------------------------------------------------------------------------
package idct_pkg;

    localparam int N_PT   = 8;
    localparam int COEF_W = 9;
    localparam int PIX_W  = 8;
    localparam int W_W    = 13;

    // cos(j*pi/16) for j = 0..8 with 20 fractional bits. Every weight is
    // derived from these and rounded down to the requested precision, which
    // keeps the table generation in integer arithmetic.
    localparam int COS_FRAC = 20;
    localparam int COS_Q20 [9] = '{1048576, 1028428, 968758, 871859, 741455,
                                   582558, 401273, 204567, 0};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // cos(m*pi/16) in Q20 for any m in 0..31, folded onto the first quadrant.
    function automatic int cos_q20(input int m);
        int mm;
        mm = m;
        if (mm > 16) mm = 32 - mm;
        if (mm > 8) return -COS_Q20[16 - mm];
        return COS_Q20[mm];
    endfunction

    // Entry (k, n) sits at bits [(k*N_PT + n)*W_W +: W_W].
    // For k = 0, 2*C(0)*cos(0) = sqrt(2) = 2*cos(pi/4), so the DC row reuses
    // the pi/4 constant. Rounding is half away from zero on the magnitude.
    function automatic logic [N_PT*N_PT*W_W-1:0] gen_w_table(input int frac);
        logic [N_PT*N_PT*W_W-1:0] t;
        int                       m;
        int                       base;
        int                       mag;
        int                       sh;
        t  = '0;
        sh = COS_FRAC - frac;
        for (int k = 0; k < N_PT; k++) begin
            for (int n = 0; n < N_PT; n++) begin
                m = ((2 * n + 1) * k) % 32;
                if (k == 0) base = 2 * COS_Q20[4];
                else        base = 2 * cos_q20(m);
                mag = (base < 0) ? -base : base;
                mag = (mag + (1 << (sh - 1))) >>> sh;
                t[(k * N_PT + n) * W_W +: W_W] = W_W'((base < 0) ? -mag : mag);
            end
        end
        return t;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [N_PT-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = N_PT - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/idct_cos_rom.sv
// ---------------------------------------------------------------------------
// idct_cos_rom
//   Combinational cosine weight ROM for the row IDCT. Selects the 8 weights
//   of basis index k, one per output lane.
//
//   Parameters:
//     COEF_FRAC : fractional bits of the weights
//   Ports:
//     k : in  3         basis (coefficient) index
//     w : out 8 x 13    weights, lane n at [n*13 +: 13], signed
// ---------------------------------------------------------------------------
module idct_cos_rom
    import idct_pkg::*;
#(
    parameter int COEF_FRAC = 10
) (
    input  logic [2:0]          k,
    output logic [N_PT*W_W-1:0] w
);

    localparam logic [N_PT*N_PT*W_W-1:0] W_TABLE = gen_w_table(COEF_FRAC);

    always_comb begin
        w = W_TABLE[int'(k) * N_PT * W_W +: N_PT * W_W];
    end

endmodule

// File: rtl/idct_row_mac.sv
// ---------------------------------------------------------------------------
// idct_row_mac
//   Sequential 8-point 1-D inverse DCT for one row. Eight parallel MAC lanes
//   consume one coefficient per cycle; results are rounded, shifted down by
//   COEF_FRAC and clamped to unsigned 8-bit pixels.
//
//   Parameters:
//     COEF_FRAC : fractional bits of the cosine weights (default 10)
//     ACC_W     : signed accumulator width per lane (default 26)
//   Ports:
//     clk       : in   clock, all state changes on rising edge
//     rst       : in   synchronous active-high reset
//     in        : in   72  X0 at [71:63] .. X7 at [8:0], signed 9-bit each
//     in_valid  : in   coefficient row valid
//     in_ready  : out  block can accept a row (IDLE only)
//     out       : out  64  p0 at [63:56] .. p7 at [7:0], unsigned 8-bit each
//     out_valid : out  pixel row valid (OUT only)
//     out_ready : in   downstream accepts the row
//     dbg_state : out  2   current FSM state (state_t encoding)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; the source holds its data stable while valid is high and
//   ready is low.
//
//   Build option IDCT_ZERO_SKIP_EN: when defined, only nonzero coefficients
//   are visited during accumulation (latency popcount+1); otherwise all
//   eight are visited (latency 9). Results are identical either way.
// ---------------------------------------------------------------------------
module idct_row_mac
    import idct_pkg::*;
#(
    parameter int COEF_FRAC = 10,
    parameter int ACC_W     = 26
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PT*COEF_W-1:0] in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_PT*PIX_W-1:0]  out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             dbg_state
);

    localparam int PROD_W = COEF_W + W_W;
    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << PIX_W) - 1);

    state_t                    state_q;
    state_t                    state_d;

    logic signed [COEF_W-1:0]  x_q   [N_PT];
    logic signed [ACC_W-1:0]   acc_q [N_PT];
    // Indices still to be accumulated; the lowest set bit is the current k.
    logic [N_PT-1:0]           pend_q;
    logic [N_PT-1:0]           visit_mask;

    logic [2:0]                k;
    logic [N_PT*W_W-1:0]       w_flat;
    logic signed [PROD_W-1:0]  prod  [N_PT];
    logic [N_PT*PIX_W-1:0]     pix_d;

    assign dbg_state = state_q;
    assign k         = lowest_set(pend_q);

`ifdef IDCT_ZERO_SKIP_EN
    // Zero coefficients contribute nothing, so they are never visited. An
    // all-zero row still spends one cycle in ACC (the result-register cycle),
    // where the cleared accumulators round to all-zero pixels.
    always_comb begin
        visit_mask = '0;
        for (int i = 0; i < N_PT; i++) begin
            visit_mask[i] = (in[(N_PT - 1 - i) * COEF_W +: COEF_W] != '0);
        end
    end
`else
    assign visit_mask = '1;
`endif

    idct_cos_rom #(
        .COEF_FRAC (COEF_FRAC)
    ) u_rom (
        .k (k),
        .w (w_flat)
    );

    // 9b x 13b signed products, one per lane.
    always_comb begin
        for (int n = 0; n < N_PT; n++) begin
            prod[n] = PROD_W'(x_q[k]) * PROD_W'($signed(w_flat[n * W_W +: W_W]));
        end
    end

    // Round, arithmetic shift, clamp to [0, 255].
    always_comb begin
        logic signed [ACC_W-1:0] rnd;
        logic signed [ACC_W-1:0] shr;
        logic [PIX_W-1:0]        px;
        pix_d = '0;
        rnd   = '0;
        shr   = '0;
        px    = '0;
        for (int n = 0; n < N_PT; n++) begin
            rnd = acc_q[n] + RND_HALF;
            shr = rnd >>> COEF_FRAC;
            if (shr[ACC_W-1])       px = '0;
            else if (shr > PIX_MAX) px = '1;
            else                    px = shr[PIX_W-1:0];
            pix_d[(N_PT - 1 - n) * PIX_W +: PIX_W] = px;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ACC;
            end
            ACC: begin
                // Once nothing is pending, this cycle registers the pixels.
                if (pend_q == '0) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            out    <= '0;
            for (int n = 0; n < N_PT; n++) begin
                x_q[n]   <= '0;
                acc_q[n] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pend_q <= visit_mask;
                        for (int n = 0; n < N_PT; n++) begin
                            x_q[n]   <= in[(N_PT - 1 - n) * COEF_W +: COEF_W];
                            acc_q[n] <= '0;
                        end
                    end
                end
                ACC: begin
                    if (pend_q != '0) begin
                        pend_q[k] <= 1'b0;
                        for (int n = 0; n < N_PT; n++) begin
                            acc_q[n] <= acc_q[n] + ACC_W'(prod[n]);
                        end
                    end else begin
                        out <= pix_d;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
